// File: rtl/value_radix_conv_if.sv
// Bus between the value counters and the radix converter: request side plus digit/status results.
interface value_radix_conv_if #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
);
  logic                  en;
  logic                  newframe;
  logic [IN_W-1:0]       some_value;
  logic                  oct_mode;
  logic [4*DIGITS-1:0]   exit_value;
  logic                  valid;
  logic                  busy;
  logic                  overflow;

  modport master (
    output en, newframe, some_value, oct_mode,
    input  exit_value, valid, busy, overflow
  );

  modport slave (
    input  en, newframe, some_value, oct_mode,
    output exit_value, valid, busy, overflow
  );
endinterface

// File: rtl/value_radix_conv.sv
// Sequential double-dabble converter: IN_W-bit binary to DIGITS decimal/octal digit nibbles.
// Define VALUE_BLANK_EN to compile in leading-zero blanking (blank glyph 4'hF).
module value_radix_conv #(
  parameter int IN_W   = 16,
  parameter int DIGITS = 5
) (
  input logic               clk,
  input logic               rst,
  value_radix_conv_if.slave bus
);
  localparam int CNT_W = $clog2(IN_W + 1);
  localparam int ACC_W = 4 * DIGITS;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_SHIFT = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [IN_W-1:0]  shift_q, shift_d;
  logic             radix_q, radix_d;
  logic [ACC_W-1:0] acc_q, acc_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ovf_int_q, ovf_int_d;
  logic [ACC_W-1:0] exit_q, exit_d;
  logic             valid_q, valid_d;
  logic             busy_q, busy_d;
  logic             overflow_q, overflow_d;
  logic [ACC_W-1:0] acc_adj;
  logic [ACC_W-1:0] result;
  logic             start;
`ifdef VALUE_BLANK_EN
  logic             lead;
`endif

  // Pre-shift adjust: any digit that would reach the base after doubling gets pushed into a carry.
  always_comb begin
    acc_adj = acc_q;
    for (int i = 0; i < DIGITS; i++) begin
      if (radix_q) begin
        if (acc_q[4*i +: 4] >= 4'd4) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd4;
      end else begin
        if (acc_q[4*i +: 4] >= 4'd5) acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
      end
    end
  end

  always_comb begin
    result = acc_q;
`ifdef VALUE_BLANK_EN
    lead = 1'b1;
`endif
    if (ovf_int_q) begin
      for (int i = 0; i < DIGITS; i++) begin
        result[4*i +: 4] = radix_q ? 4'd7 : 4'd9;
      end
    end
`ifdef VALUE_BLANK_EN
    else begin
      for (int i = DIGITS - 1; i > 0; i--) begin
        if (lead && (acc_q[4*i +: 4] == 4'd0)) result[4*i +: 4] = 4'hF;
        else lead = 1'b0;
      end
    end
`endif
  end

  // busy_q stays high through the valid cycle, which also blocks a same-cycle restart.
  assign start = bus.en && bus.newframe && (state_q == ST_IDLE) && !busy_q;

  always_comb begin
    state_d    = state_q;
    shift_d    = shift_q;
    radix_d    = radix_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    ovf_int_d  = ovf_int_q;
    exit_d     = exit_q;
    valid_d    = 1'b0;
    busy_d     = busy_q;
    overflow_d = overflow_q;
    case (state_q)
      ST_IDLE: begin
        busy_d = 1'b0;
        if (start) begin
          shift_d   = bus.some_value;
          radix_d   = bus.oct_mode;
          acc_d     = '0;
          ovf_int_d = 1'b0;
          cnt_d     = CNT_W'(IN_W);
          busy_d    = 1'b1;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        {acc_d, shift_d} = {acc_adj[ACC_W-2:0], shift_q, 1'b0};
        ovf_int_d        = ovf_int_q | acc_adj[ACC_W-1];
        cnt_d            = cnt_q - CNT_W'(1);
        busy_d           = 1'b1;
        if (cnt_q == CNT_W'(1)) state_d = ST_DONE;
      end
      ST_DONE: begin
        exit_d     = result;
        overflow_d = ovf_int_q;
        valid_d    = 1'b1;
        busy_d     = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      shift_q    <= '0;
      radix_q    <= 1'b0;
      acc_q      <= '0;
      cnt_q      <= '0;
      ovf_int_q  <= 1'b0;
      exit_q     <= '0;
      valid_q    <= 1'b0;
      busy_q     <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      shift_q    <= shift_d;
      radix_q    <= radix_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      ovf_int_q  <= ovf_int_d;
      exit_q     <= exit_d;
      valid_q    <= valid_d;
      busy_q     <= busy_d;
      overflow_q <= overflow_d;
    end
  end

  assign bus.exit_value = exit_q;
  assign bus.valid      = valid_q;
  assign bus.busy       = busy_q;
  assign bus.overflow   = overflow_q;
endmodule

// File: tb/tb_value_radix_conv.sv
// Directed self-checking bench for value_radix_conv; expected digits are hand-computed,
// with the blanked forms selected when VALUE_BLANK_EN is defined.
module tb_value_radix_conv;
  localparam int IN_W   = 16;
  localparam int DIGITS = 5;

`ifdef VALUE_BLANK_EN
  localparam logic [19:0] EXP_OCT1234 = 20'hF1234;
  localparam logic [19:0] EXP_ZERO    = 20'hFFFF0;
  localparam logic [19:0] EXP_42      = 20'hFFF42;
  localparam logic [19:0] EXP_7       = 20'hFFFF7;
  localparam logic [19:0] EXP_500     = 20'hFF500;
`else
  localparam logic [19:0] EXP_OCT1234 = 20'h01234;
  localparam logic [19:0] EXP_ZERO    = 20'h00000;
  localparam logic [19:0] EXP_42      = 20'h00042;
  localparam logic [19:0] EXP_7       = 20'h00007;
  localparam logic [19:0] EXP_500     = 20'h00500;
`endif

  logic clk = 1'b0;
  logic rst;
  int   assert_count = 0;
  int   fail_count   = 0;
  int   valid_count;
  logic [19:0] captured;

  value_radix_conv_if #(.IN_W(IN_W), .DIGITS(DIGITS)) bus ();

  value_radix_conv #(.IN_W(IN_W), .DIGITS(DIGITS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    assert_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  // Returns at the falling edge just after the start edge.
  task automatic applyStimulus(input logic [15:0] value, input logic oct);
    @(negedge clk);
    bus.some_value = value;
    bus.oct_mode   = oct;
    bus.en         = 1'b1;
    bus.newframe   = 1'b1;
    @(negedge clk);
    bus.newframe   = 1'b0;
  endtask

  task automatic runConversion(input string tag, input logic [15:0] value, input logic oct,
                               input logic [19:0] exp_value, input logic exp_ovf);
    int cycles;
    bit seen;
    applyStimulus(value, oct);
    checkOutput({tag, "_busy_start"}, 32'(bus.busy), 32'd1);
    cycles = 0;
    seen   = 1'b0;
    while (!seen && cycles < 40) begin
      @(negedge clk);
      cycles++;
      if (bus.valid) seen = 1'b1;
    end
    checkOutput({tag, "_latency"}, 32'(cycles), 32'd17);
    checkOutput({tag, "_value"}, 32'(bus.exit_value), 32'(exp_value));
    checkOutput({tag, "_ovf"}, 32'(bus.overflow), 32'(exp_ovf));
    checkOutput({tag, "_busy_last"}, 32'(bus.busy), 32'd1);
    @(negedge clk);
    checkOutput({tag, "_valid_pulse"}, 32'(bus.valid), 32'd0);
    checkOutput({tag, "_busy_end"}, 32'(bus.busy), 32'd0);
    checkOutput({tag, "_value_hold"}, 32'(bus.exit_value), 32'(exp_value));
  endtask

  initial begin
    rst            = 1'b1;
    bus.en         = 1'b0;
    bus.newframe   = 1'b0;
    bus.some_value = '0;
    bus.oct_mode   = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    checkOutput("reset_value", 32'(bus.exit_value), 32'd0);
    checkOutput("reset_valid", 32'(bus.valid), 32'd0);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    checkOutput("reset_ovf", 32'(bus.overflow), 32'd0);

    runConversion("dec12345", 16'd12345, 1'b0, 20'h12345, 1'b0);
    runConversion("oct1234", 16'o1234, 1'b1, EXP_OCT1234, 1'b0);
    runConversion("dec0", 16'd0, 1'b0, EXP_ZERO, 1'b0);
    runConversion("dec42", 16'd42, 1'b0, EXP_42, 1'b0);
    runConversion("dec65535", 16'hFFFF, 1'b0, 20'h65535, 1'b0);
    runConversion("octFFFF", 16'hFFFF, 1'b1, 20'h77777, 1'b1);
    runConversion("dec7", 16'd7, 1'b0, EXP_7, 1'b0);
    runConversion("octFFFF_again", 16'hFFFF, 1'b1, 20'h77777, 1'b1);

    // Reset in the middle of a conversion of 500.
    applyStimulus(16'd500, 1'b0);
    repeat (5) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checkOutput("midrst_value", 32'(bus.exit_value), 32'd0);
    checkOutput("midrst_valid", 32'(bus.valid), 32'd0);
    checkOutput("midrst_busy", 32'(bus.busy), 32'd0);
    checkOutput("midrst_ovf", 32'(bus.overflow), 32'd0);
    rst = 1'b0;
    valid_count = 0;
    for (int c = 0; c < 25; c++) begin
      @(negedge clk);
      if (bus.valid) valid_count++;
    end
    checkOutput("midrst_no_valid", 32'(valid_count), 32'd0);

    // Second newframe sampled at edge 5 must be ignored.
    applyStimulus(16'd500, 1'b0);
    valid_count = 0;
    captured    = '0;
    for (int c = 1; c <= 30; c++) begin
      if (c == 5) begin
        bus.some_value = 16'd999;
        bus.newframe   = 1'b1;
      end
      @(negedge clk);
      bus.newframe = 1'b0;
      if (bus.valid) begin
        valid_count++;
        captured = bus.exit_value;
      end
    end
    checkOutput("collide_valid_count", 32'(valid_count), 32'd1);
    checkOutput("collide_value", 32'(captured), 32'(EXP_500));

    // newframe with en low never starts a conversion.
    @(negedge clk);
    bus.en         = 1'b0;
    bus.some_value = 16'd123;
    bus.newframe   = 1'b1;
    @(negedge clk);
    bus.newframe = 1'b0;
    checkOutput("en_low_busy", 32'(bus.busy), 32'd0);
    valid_count = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (bus.valid || bus.busy) valid_count++;
    end
    checkOutput("en_low_no_activity", 32'(valid_count), 32'd0);
    checkOutput("en_low_value_hold", 32'(bus.exit_value), 32'(EXP_500));

    $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
    $finish;
  end
endmodule
